// File: rtl/can_pkg.sv
// ---------------------------------------------------------------------------
// can_pkg
// Shared definitions for the CAN error/overload frame transmitter:
//   - FSM state encoding for the frame sequencer
//   - field lengths (in CAN bits) and the superposition limit
//   - counter widths sized to those constants
// ---------------------------------------------------------------------------
package can_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FLAG       = 3'd1,
        DELIM_WAIT = 3'd2,
        DELIM      = 3'd3,
        IFS        = 3'd4
    } can_efs_state_t;

    // Field lengths in bit times
    localparam int unsigned FLAG_BITS    = 6;
    localparam int unsigned DELIM_BITS   = 8;
    localparam int unsigned IFS_BITS     = 3;
    // Dominant bits tolerated after the flag before declaring the bus stuck
    localparam int unsigned MAX_SUPERPOS = 8;

    // Bit-in-field counter: must hold DELIM_BITS-1 (largest field index)
    localparam int unsigned BIT_CNT_W = 3;
    // Dominant-sample counter: must hold MAX_SUPERPOS itself
    localparam int unsigned SUP_CNT_W = 4;

    // Width of a counter that runs 0..n-1 (never narrower than one bit)
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : can_pkg

// File: rtl/can_bit_timer.sv
// ---------------------------------------------------------------------------
// can_bit_timer
// Bit-time generator: a counter running 0..CLKS_PER_BIT-1 that wraps on its
// own and can be forced back to 0.
//
// Parameters
//   CLKS_PER_BIT    clock cycles per CAN bit (>= 4)
// Ports
//   i_clk           clock
//   i_reset         synchronous active-high reset (counter -> 0)
//   i_restart       force the counter to 0 on the next edge
//   o_sample_pulse  high while counter == CLKS_PER_BIT/2 (bus sample point)
//   o_bit_end       high while counter == CLKS_PER_BIT-1 (last cycle of bit)
//   o_pre_end       high while counter == CLKS_PER_BIT-2 (cycle before end)
// ---------------------------------------------------------------------------
module can_bit_timer
    import can_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10
)
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_restart,
    output logic o_sample_pulse,
    output logic o_bit_end,
    output logic o_pre_end
);

    localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Free-running bit counter with forced restart
    always_ff @(posedge i_clk) begin
        if (i_reset || i_restart) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_sample_pulse = (r_cnt == CNT_W'(CLKS_PER_BIT / 2));
    assign o_bit_end      = w_last;
    assign o_pre_end      = (r_cnt == CNT_W'(CLKS_PER_BIT - 2));

endmodule : can_bit_timer

// File: rtl/can_error_frame_tx.sv
// ---------------------------------------------------------------------------
// can_error_frame_tx
// Transmits a CAN error frame after a form-error request:
//   6-bit error flag -> wait for recessive bus (superposition) ->
//   8-bit delimiter -> 3-bit intermission -> Done.
// A bus stuck dominant for MAX_SUPERPOS bits after the flag aborts the frame
// with a Stuck_error pulse.
//
// Optional feature (macro CAN_OVERLOAD_FRAME_EN): adds input Overload_req,
// which sends the same frame shape with an always-dominant flag. It is
// accepted in IDLE or IFS (aborting the intermission); a simultaneous
// Form_error takes precedence and selects an error frame instead.
//
// Parameters
//   CLKS_PER_BIT   clock cycles per CAN bit (>= 4)
// Ports
//   Clock_TB       clock
//   Reset          synchronous active-high reset
//   Form_error     one-cycle error frame request
//   Error_passive  flag level: 0 active (dominant), 1 passive (recessive)
//   Bit_Entrada    bus readback (0 dominant)
//   Bit_Saida      transmitted bit (registered)
//   Busy           high in every state except IDLE (registered)
//   Done           one-cycle pulse in the last cycle of the intermission
//   Stuck_error    one-cycle pulse in the last cycle of the 8th dominant bit
//   Overload_req   overload frame request (only with CAN_OVERLOAD_FRAME_EN)
// ---------------------------------------------------------------------------
module can_error_frame_tx
    import can_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10
)
(
    input  logic Clock_TB,
    input  logic Reset,
    input  logic Form_error,
    input  logic Error_passive,
    input  logic Bit_Entrada,
    output logic Bit_Saida,
    output logic Busy,
    output logic Done,
    output logic Stuck_error
`ifdef CAN_OVERLOAD_FRAME_EN
    ,
    input  logic Overload_req
`endif
);

    // State and counters
    can_efs_state_t         r_state;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [SUP_CNT_W-1:0]   r_dom_cnt;
    logic                   r_rec_seen;
    logic                   r_dom_seen;
    logic                   r_flag_lvl;

    // Registered outputs
    logic                   r_bit_saida;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_stuck;

    // Next-state values
    can_efs_state_t         w_next_state;
    logic [BIT_CNT_W-1:0]   w_next_bit_cnt;
    logic [SUP_CNT_W-1:0]   w_next_dom_cnt;
    logic                   w_next_rec_seen;
    logic                   w_next_dom_seen;
    logic                   w_next_flag_lvl;
    logic                   w_done_nxt;
    logic                   w_stuck_nxt;

    // Timer interface
    logic                   w_restart;
    logic                   w_sample;
    logic                   w_bit_end;
    logic                   w_pre_end;

    logic                   w_ovl_req;

`ifdef CAN_OVERLOAD_FRAME_EN
    assign w_ovl_req = Overload_req;
`else
    assign w_ovl_req = 1'b0;
`endif

    can_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .i_clk          (Clock_TB),
        .i_reset        (Reset),
        .i_restart      (w_restart),
        .o_sample_pulse (w_sample),
        .o_bit_end      (w_bit_end),
        .o_pre_end      (w_pre_end)
    );

    // Next-state, counter and pulse look-ahead logic
    always_comb begin
        w_next_state    = r_state;
        w_next_bit_cnt  = r_bit_cnt;
        w_next_dom_cnt  = r_dom_cnt;
        w_next_rec_seen = r_rec_seen;
        w_next_dom_seen = r_dom_seen;
        w_next_flag_lvl = r_flag_lvl;
        w_restart       = 1'b0;
        w_done_nxt      = 1'b0;
        w_stuck_nxt     = 1'b0;

        unique case (r_state)
            IDLE: begin
                // Hold the timer at 0 so the flag starts on a fresh bit
                w_restart = 1'b1;
                if (Form_error) begin
                    w_next_state    = FLAG;
                    w_next_flag_lvl = Error_passive;
                    w_next_bit_cnt  = '0;
                end else if (w_ovl_req) begin
                    w_next_state    = FLAG;
                    w_next_flag_lvl = 1'b0;
                    w_next_bit_cnt  = '0;
                end
            end

            FLAG: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == BIT_CNT_W'(FLAG_BITS - 1)) begin
                        w_next_state    = DELIM_WAIT;
                        w_next_bit_cnt  = '0;
                        w_next_dom_cnt  = '0;
                        w_next_rec_seen = 1'b0;
                    end else begin
                        w_next_bit_cnt = r_bit_cnt + BIT_CNT_W'(1);
                    end
                end
            end

            DELIM_WAIT: begin
                if (w_sample) begin
                    if (Bit_Entrada) begin
                        w_next_rec_seen = 1'b1;
                    end else if (r_dom_cnt < SUP_CNT_W'(MAX_SUPERPOS)) begin
                        w_next_dom_cnt = r_dom_cnt + SUP_CNT_W'(1);
                    end
                end
                if (w_bit_end) begin
                    if (r_rec_seen) begin
                        // The recessive bit is delimiter bit 1
                        w_next_state    = DELIM;
                        w_next_bit_cnt  = BIT_CNT_W'(1);
                        w_next_dom_seen = 1'b0;
                    end else if (r_dom_cnt >= SUP_CNT_W'(MAX_SUPERPOS)) begin
                        w_next_state = IDLE;
                    end
                end
                // Uses next values: with short bits the sample and the
                // pre-end cycle can coincide
                w_stuck_nxt = w_pre_end && !w_next_rec_seen &&
                              (w_next_dom_cnt >= SUP_CNT_W'(MAX_SUPERPOS));
            end

            DELIM: begin
                if (w_sample && !Bit_Entrada) begin
                    w_next_dom_seen = 1'b1;
                end
                if (w_bit_end) begin
                    if (r_dom_seen) begin
                        // Dominant inside the delimiter: send the flag again
                        w_next_state    = FLAG;
                        w_next_bit_cnt  = '0;
                        w_next_dom_seen = 1'b0;
                    end else if (r_bit_cnt == BIT_CNT_W'(DELIM_BITS - 1)) begin
                        w_next_state   = IFS;
                        w_next_bit_cnt = '0;
                    end else begin
                        w_next_bit_cnt = r_bit_cnt + BIT_CNT_W'(1);
                    end
                end
            end

            IFS: begin
                if (w_ovl_req) begin
                    // Abort the intermission; a coincident Form_error wins
                    w_restart       = 1'b1;
                    w_next_state    = FLAG;
                    w_next_flag_lvl = Form_error ? Error_passive : 1'b0;
                    w_next_bit_cnt  = '0;
                end else begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == BIT_CNT_W'(IFS_BITS - 1)) begin
                            w_next_state = IDLE;
                        end else begin
                            w_next_bit_cnt = r_bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                    // Raise Done for the final cycle of the last IFS bit
                    w_done_nxt = w_pre_end &&
                                 (r_bit_cnt == BIT_CNT_W'(IFS_BITS - 1));
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge Clock_TB) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_dom_cnt   <= '0;
            r_rec_seen  <= 1'b0;
            r_dom_seen  <= 1'b0;
            r_flag_lvl  <= 1'b0;
            r_bit_saida <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_stuck     <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_bit_cnt   <= w_next_bit_cnt;
            r_dom_cnt   <= w_next_dom_cnt;
            r_rec_seen  <= w_next_rec_seen;
            r_dom_seen  <= w_next_dom_seen;
            r_flag_lvl  <= w_next_flag_lvl;
            r_bit_saida <= (w_next_state == FLAG) ? w_next_flag_lvl : 1'b1;
            r_busy      <= (w_next_state != IDLE);
            r_done      <= w_done_nxt;
            r_stuck     <= w_stuck_nxt;
        end
    end

    assign Bit_Saida   = r_bit_saida;
    assign Busy        = r_busy;
    assign Done        = r_done;
    assign Stuck_error = r_stuck;

endmodule : can_error_frame_tx

// File: tb/tb_can_error_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_can_error_frame_tx
// Directed bench for can_error_frame_tx with CLKS_PER_BIT = 10. Cycle 0 is
// the cycle in which Form_error is driven; the bus is the wired-AND of the
// DUT output and a bench-forced dominant level. Outputs are logged on the
// falling edge and checked against hand-computed cycle numbers.
// ---------------------------------------------------------------------------
module tb_can_error_frame_tx;

    localparam int unsigned CPB     = 10;
    localparam int          LOG_LEN = 400;

    localparam int SEL_OUT   = 0;
    localparam int SEL_BUSY  = 1;
    localparam int SEL_DONE  = 2;
    localparam int SEL_STUCK = 3;

    logic clk = 1'b0;
    logic rst;
    logic form;
    logic passive;
    logic force_dom;
    logic bus;
    logic bit_saida;
    logic busy;
    logic done;
    logic stuck;
`ifdef CAN_OVERLOAD_FRAME_EN
    logic ovl;
`endif

    logic log_out   [LOG_LEN];
    logic log_busy  [LOG_LEN];
    logic log_done  [LOG_LEN];
    logic log_stuck [LOG_LEN];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    assign bus = bit_saida & ~force_dom;

    can_error_frame_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .Clock_TB      (clk),
        .Reset         (rst),
        .Form_error    (form),
        .Error_passive (passive),
        .Bit_Entrada   (bus),
        .Bit_Saida     (bit_saida),
        .Busy          (busy),
        .Done          (done),
        .Stuck_error   (stuck)
`ifdef CAN_OVERLOAD_FRAME_EN
        ,
        .Overload_req  (ovl)
`endif
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic pick(input int sel, input int c);
        case (sel)
            SEL_OUT:  return log_out[c];
            SEL_BUSY: return log_busy[c];
            SEL_DONE: return log_done[c];
            default:  return log_stuck[c];
        endcase
    endfunction

    function automatic int count_ones(input int sel, input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) n += int'(pick(sel, c));
        return n;
    endfunction

    function automatic int first_one(input int sel, input int lo, input int hi);
        for (int c = lo; c <= hi; c++) if (pick(sel, c)) return c;
        return -1;
    endfunction

    task automatic apply_reset();
        rst       = 1'b1;
        form      = 1'b0;
        force_dom = 1'b0;
`ifdef CAN_OVERLOAD_FRAME_EN
        ovl       = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
    endtask

    // One scenario: cycle 0 starts at the current posedge
    task automatic run_scn(input int len, input logic pas, input int req2,
                           input int rst_at, input int dom_from, input int dom_to,
                           input int ovl_a, input int ovl_b);
        passive = pas;
        for (int c = 0; c < len; c++) begin
            #1;
            form      = (c == 0) || (c == req2);
            rst       = (c == rst_at);
            force_dom = (c >= dom_from) && (c <= dom_to);
`ifdef CAN_OVERLOAD_FRAME_EN
            ovl       = (c == ovl_a) || (c == ovl_b);
`endif
            @(negedge clk);
            log_out[c]   = bit_saida;
            log_busy[c]  = busy;
            log_done[c]  = done;
            log_stuck[c] = stuck;
            @(posedge clk);
        end
        #1;
        form      = 1'b0;
        rst       = 1'b0;
        force_dom = 1'b0;
`ifdef CAN_OVERLOAD_FRAME_EN
        ovl       = 1'b0;
`else
        if (ovl_a != ovl_b) begin end
`endif
    endtask

    initial begin
        // Reset wins over a pending request
        rst       = 1'b1;
        form      = 1'b1;
        passive   = 1'b0;
        force_dom = 1'b0;
`ifdef CAN_OVERLOAD_FRAME_EN
        ovl       = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_bit_saida", int'(bit_saida), 1);
        check_eq("rst_busy",      int'(busy),      0);
        check_eq("rst_done",      int'(done),      0);
        check_eq("rst_stuck",     int'(stuck),     0);

        // Active frame, second request at cycle 20 must be ignored
        apply_reset();
        run_scn(185, 1'b0, 20, -1, -1, -2, -1, -1);
        check_eq("act_out_c0",      int'(log_out[0]), 1);
        check_eq("act_flag_ones",   count_ones(SEL_OUT, 1, 60), 0);
        check_eq("act_recessive",   count_ones(SEL_OUT, 61, 184), 124);
        check_eq("act_done_cycle",  first_one(SEL_DONE, 0, 184), 170);
        check_eq("act_done_pulses", count_ones(SEL_DONE, 0, 184), 1);
        check_eq("act_busy_c0",     int'(log_busy[0]), 0);
        check_eq("act_busy_c170",   int'(log_busy[170]), 1);
        check_eq("act_busy_c171",   int'(log_busy[171]), 0);
        check_eq("act_no_stuck",    count_ones(SEL_STUCK, 0, 184), 0);

        // Passive frame: output never dominant
        apply_reset();
        run_scn(185, 1'b1, -1, -1, -1, -2, -1, -1);
        check_eq("pas_all_recessive", count_ones(SEL_OUT, 0, 184), 185);
        check_eq("pas_done_cycle",    first_one(SEL_DONE, 0, 184), 170);
        check_eq("pas_busy_c1",       int'(log_busy[1]), 1);
        check_eq("pas_busy_c171",     int'(log_busy[171]), 0);

        // Superposition: bus dominant for 3 bits after the flag
        apply_reset();
        run_scn(215, 1'b0, -1, -1, 61, 90, -1, -1);
        check_eq("sup_flag_ones",   count_ones(SEL_OUT, 1, 60), 0);
        check_eq("sup_recessive",   count_ones(SEL_OUT, 61, 214), 154);
        check_eq("sup_done_cycle",  first_one(SEL_DONE, 0, 214), 200);
        check_eq("sup_done_pulses", count_ones(SEL_DONE, 0, 214), 1);
        check_eq("sup_no_stuck",    count_ones(SEL_STUCK, 0, 214), 0);

        // Stuck bus
        apply_reset();
        run_scn(160, 1'b0, -1, -1, 0, 159, -1, -1);
        check_eq("stk_out_c60",      int'(log_out[60]), 0);
        check_eq("stk_out_c61",      int'(log_out[61]), 1);
        check_eq("stk_stuck_cycle",  first_one(SEL_STUCK, 0, 159), 140);
        check_eq("stk_stuck_pulses", count_ones(SEL_STUCK, 0, 159), 1);
        check_eq("stk_no_done",      count_ones(SEL_DONE, 0, 159), 0);
        check_eq("stk_busy_c140",    int'(log_busy[140]), 1);
        check_eq("stk_busy_c141",    int'(log_busy[141]), 0);
        check_eq("stk_out_c141",     int'(log_out[141]), 1);

        // Reset in the middle of the flag
        apply_reset();
        run_scn(60, 1'b0, -1, 35, -1, -2, -1, -1);
        check_eq("mrst_out_c35",  int'(log_out[35]), 0);
        check_eq("mrst_busy_c35", int'(log_busy[35]), 1);
        check_eq("mrst_out_c36",  int'(log_out[36]), 1);
        check_eq("mrst_busy_after", count_ones(SEL_BUSY, 36, 59), 0);
        check_eq("mrst_no_done",  count_ones(SEL_DONE, 0, 59), 0);

`ifdef CAN_OVERLOAD_FRAME_EN
        // Passive error frame (Form_error beats Overload_req at cycle 0),
        // then an overload request in IFS starts a dominant flag
        apply_reset();
        run_scn(335, 1'b1, -1, -1, -1, -2, 0, 150);
        check_eq("ovl_form_wins",   int'(log_out[1]), 1);
        check_eq("ovl_out_c150",    int'(log_out[150]), 1);
        check_eq("ovl_flag_ones",   count_ones(SEL_OUT, 151, 210), 0);
        check_eq("ovl_out_c211",    int'(log_out[211]), 1);
        check_eq("ovl_done_cycle",  first_one(SEL_DONE, 0, 334), 320);
        check_eq("ovl_done_pulses", count_ones(SEL_DONE, 0, 334), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_can_error_frame_tx
